id_fwd_scoreboard: RTL

ID_FWD_SCOREBOARD -- requirements
Module: id_fwd_scoreboard

---
 rtl/id_fwd_scoreboard.sv | 169 ++++++++++++++++
 1 files changed

// File: rtl/id_fwd_scoreboard.sv
// Decode-stage operand forwarding and multi-cycle scoreboard feeding the EX register.
// Optional stall counter is built only when ID_STALL_CNT_EN is defined.
module id_fwd_scoreboard #(
   parameter int XLEN = 32,
   parameter int NSRC = 3,
   parameter int NREG = 32
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 dec_valid_i,
   input  logic [4:0]           dec_rs1_addr_i,
   input  logic [4:0]           dec_rs2_addr_i,
   input  logic [4:0]           dec_rd_addr_i,
   input  logic                 dec_rs1_used_i,
   input  logic                 dec_rs2_used_i,
   input  logic                 dec_rd_wr_i,
   input  logic                 dec_is_mc_i,
   input  logic [XLEN-1:0]      rf_rs1_i,
   input  logic [XLEN-1:0]      rf_rs2_i,
   input  logic [NSRC-1:0]      fwd_valid_i,
   input  logic [NSRC-1:0]      fwd_ready_i,
   input  logic [5*NSRC-1:0]    fwd_addr_i,
   input  logic [XLEN*NSRC-1:0] fwd_data_i,
   input  logic                 mc_done_i,
   input  logic [4:0]           mc_rd_addr_i,
   input  logic [XLEN-1:0]      mc_rd_data_i,
   input  logic                 ex_ready_i,
   input  logic                 flush_i,
   output logic                 ex_valid_o,
   output logic [XLEN-1:0]      ex_rs1_o,
   output logic [XLEN-1:0]      ex_rs2_o,
   output logic [4:0]           ex_rd_addr_o,
   output logic                 ex_rd_wr_o,
   output logic                 ex_is_mc_o,
   output logic                 stall_o,
   output logic [NREG-1:0]      sb_busy_o,
   output logic [31:0]          stall_cnt_o
);

   logic [NREG-1:0] busy_q;
   logic [NREG-1:0] busy_eff;
   logic [NREG-1:0] clr_vec;
   logic [NREG-1:0] set_vec;
   logic [XLEN-1:0] rs1_val;
   logic [XLEN-1:0] rs2_val;
   logic            rs1_pend;
   logic            rs2_pend;
   logic            issue;

   // Lowest-index ready forward wins, then the multi-cycle writeback, then the register file.
   function automatic logic [XLEN-1:0] resolve(input logic [4:0] addr, input logic [XLEN-1:0] rf);
      logic            hit;
      logic [XLEN-1:0] val;
      hit = 1'b0;
      val = rf;
      if (addr == 5'd0) begin
         val = '0;
      end else begin
         for (int k = 0; k < NSRC; k++) begin
            if (!hit && fwd_valid_i[k] && fwd_ready_i[k] && fwd_addr_i[5*k +: 5] == addr) begin
               hit = 1'b1;
               val = fwd_data_i[XLEN*k +: XLEN];
            end
         end
         if (!hit && mc_done_i && mc_rd_addr_i == addr) val = mc_rd_data_i;
      end
      return val;
   endfunction

   // A pending (not-ready) forward stalls only if no higher-priority source is ready.
   function automatic logic pending(input logic [4:0] addr);
      logic seen_ready;
      logic pend;
      seen_ready = 1'b0;
      pend       = 1'b0;
      if (addr != 5'd0) begin
         for (int k = 0; k < NSRC; k++) begin
            if (fwd_valid_i[k] && fwd_addr_i[5*k +: 5] == addr) begin
               if (fwd_ready_i[k]) seen_ready = 1'b1;
               else if (!seen_ready) pend = 1'b1;
            end
         end
      end
      return pend;
   endfunction

   always_comb begin
      clr_vec = '0;
      if (mc_done_i) clr_vec[mc_rd_addr_i] = 1'b1;
      busy_eff = busy_q & ~clr_vec;
      rs1_val  = resolve(dec_rs1_addr_i, rf_rs1_i);
      rs2_val  = resolve(dec_rs2_addr_i, rf_rs2_i);
      rs1_pend = pending(dec_rs1_addr_i);
      rs2_pend = pending(dec_rs2_addr_i);
   end

   always_comb begin
      stall_o = 1'b0;
      if (dec_valid_i) begin
         if (dec_rs1_used_i && dec_rs1_addr_i != 5'd0 && (rs1_pend || busy_eff[dec_rs1_addr_i]))
            stall_o = 1'b1;
         if (dec_rs2_used_i && dec_rs2_addr_i != 5'd0 && (rs2_pend || busy_eff[dec_rs2_addr_i]))
            stall_o = 1'b1;
         if (dec_rd_wr_i && dec_rd_addr_i != 5'd0 && busy_eff[dec_rd_addr_i])
            stall_o = 1'b1;
         if (dec_is_mc_i && (|busy_eff))
            stall_o = 1'b1;
      end
   end

   assign issue = dec_valid_i && !stall_o && ex_ready_i && !flush_i;

   always_comb begin
      set_vec = '0;
      if (issue && dec_is_mc_i && dec_rd_wr_i && dec_rd_addr_i != 5'd0)
         set_vec[dec_rd_addr_i] = 1'b1;
   end

   // Set is applied after clear so an mc op may retarget a register freed this cycle.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         busy_q <= '0;
      end else begin
         busy_q    <= (busy_q & ~clr_vec) | set_vec;
         busy_q[0] <= 1'b0;
      end
   end

   assign sb_busy_o = busy_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ex_valid_o   <= 1'b0;
         ex_rs1_o     <= '0;
         ex_rs2_o     <= '0;
         ex_rd_addr_o <= '0;
         ex_rd_wr_o   <= 1'b0;
         ex_is_mc_o   <= 1'b0;
      end else if (flush_i || (ex_ready_i && !issue)) begin
         ex_valid_o <= 1'b0;
         ex_rd_wr_o <= 1'b0;
         ex_is_mc_o <= 1'b0;
      end else if (ex_ready_i) begin
         ex_valid_o   <= 1'b1;
         ex_rs1_o     <= rs1_val;
         ex_rs2_o     <= rs2_val;
         ex_rd_addr_o <= dec_rd_addr_i;
         ex_rd_wr_o   <= dec_rd_wr_i;
         ex_is_mc_o   <= dec_is_mc_i;
      end
   end

`ifdef ID_STALL_CNT_EN
   logic [31:0] stall_cnt_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         stall_cnt_q <= '0;
      end else if (dec_valid_i && stall_o && stall_cnt_q != 32'hFFFF_FFFF) begin
         stall_cnt_q <= stall_cnt_q + 32'd1;
      end
   end

   assign stall_cnt_o = stall_cnt_q;
`else
   assign stall_cnt_o = '0;
`endif

endmodule
